// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB, honouring arbiter stall, debug halt and clock enable.
module core_seq_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_en,
  input  logic          i_stall,
  input  logic          i_halt_req,
  output logic          o_halted,
  output logic          o_fetch_req,
  input  logic          i_fetch_ack,
  output logic          o_dec_en,
  input  logic          i_illegal,
  output logic          o_exec_en,
  input  logic          i_is_load,
  input  logic          i_is_store,
  input  logic          i_br_taken,
  output logic          o_lsu_req,
  input  logic          i_lsu_ack,
  output logic          o_wb_en,
  output logic          o_pc_inc,
  output logic          o_pc_load,
  output logic          o_trap,
  output logic [CW-1:0] o_instret
);

  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_FETCH  = 3'd1;
  localparam logic [SW-1:0] S_DECODE = 3'd2;
  localparam logic [SW-1:0] S_EXEC   = 3'd3;
  localparam logic [SW-1:0] S_MEM    = 3'd4;
  localparam logic [SW-1:0] S_WB     = 3'd5;
  localparam logic [SW-1:0] S_HALT   = 3'd6;

  // The PC this block steers advances by 4, so it needs at least 3 address bits.
  if (AW < 3) begin : g_aw_check
    $error("core_seq_ctrl: AW must be at least 3");
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          ld;
  logic          st;
  logic          br;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else if (i_clk_en) begin
      state <= state_nxt;
    end
  end

  // Instruction class captured in EXEC for use by MEM/WB
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld <= 1'b0;
      st <= 1'b0;
      br <= 1'b0;
    end else if (i_clk_en && (state == S_EXEC)) begin
      ld <= i_is_load;
      st <= i_is_store;
      br <= i_br_taken;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CW
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instret <= '0;
    end else if (i_clk_en && (state == S_WB)) begin
      o_instret <= o_instret + CW'(1);
    end
  end

  // Next-state and output decode; strobes are qualified by i_clk_en so each
  // is seen exactly once, request levels only by the stall line.
  always_comb begin
    state_nxt   = state;
    o_halted    = 1'b0;
    o_fetch_req = 1'b0;
    o_dec_en    = 1'b0;
    o_exec_en   = 1'b0;
    o_lsu_req   = 1'b0;
    o_wb_en     = 1'b0;
    o_pc_inc    = 1'b0;
    o_pc_load   = 1'b0;
    o_trap      = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = i_halt_req ? S_HALT : S_FETCH;
      end
      S_FETCH: begin
        o_fetch_req = !i_stall;
        if (i_fetch_ack) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        o_dec_en = i_clk_en;
        if (i_illegal) begin
          o_trap    = i_clk_en;
          o_pc_load = i_clk_en;
          state_nxt = i_halt_req ? S_HALT : S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        o_exec_en = i_clk_en;
        state_nxt = (i_is_load || i_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        o_lsu_req = !i_stall;
        if (i_lsu_ack) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        // A load+store combination behaves as a load and writes back.
        o_wb_en   = i_clk_en && (ld || !st);
        o_pc_load = i_clk_en && br;
        o_pc_inc  = i_clk_en && !br;
        state_nxt = i_halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (!i_halt_req) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed vector bench for core_seq_ctrl: table of per-cycle inputs and expected
// outputs, plus hand sequences for async reset in MEM and halt from IDLE.
module tb_core_seq_ctrl;

  localparam int unsigned CW = 64;

  // input bit positions: {en, stall, halt, fack, illegal, load, store, br, lack}
  localparam logic [8:0] I_EN    = 9'b100000000;
  localparam logic [8:0] I_STALL = 9'b010000000;
  localparam logic [8:0] I_HALT  = 9'b001000000;
  localparam logic [8:0] I_FACK  = 9'b000100000;
  localparam logic [8:0] I_ILL   = 9'b000010000;
  localparam logic [8:0] I_LOAD  = 9'b000001000;
  localparam logic [8:0] I_STORE = 9'b000000100;
  localparam logic [8:0] I_BR    = 9'b000000010;
  localparam logic [8:0] I_LACK  = 9'b000000001;

  // output bit positions: {halted, fetch_req, dec, exec, lsu_req, wb, inc, load, trap}
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_HALT  = 9'b100000000;
  localparam logic [8:0] O_FREQ  = 9'b010000000;
  localparam logic [8:0] O_DEC   = 9'b001000000;
  localparam logic [8:0] O_EXE   = 9'b000100000;
  localparam logic [8:0] O_LSU   = 9'b000010000;
  localparam logic [8:0] O_WB    = 9'b000001000;
  localparam logic [8:0] O_INC   = 9'b000000100;
  localparam logic [8:0] O_PCL   = 9'b000000010;
  localparam logic [8:0] O_TRAP  = 9'b000000001;

  typedef struct {
    string            name;
    logic [8:0]       in;
    logic [8:0]       exp;
    longint unsigned  cnt;
  } vec_t;

  logic clk, rst_n;
  logic clk_en, stall, halt_req, fetch_ack, illegal, is_load, is_store, br_taken, lsu_ack;
  logic halted, fetch_req, dec_en, exec_en, lsu_req, wb_en, pc_inc, pc_load, trap;
  logic [CW-1:0] instret;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  core_seq_ctrl #(.AW(32), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_stall(stall),
    .i_halt_req(halt_req), .o_halted(halted), .o_fetch_req(fetch_req),
    .i_fetch_ack(fetch_ack), .o_dec_en(dec_en), .i_illegal(illegal),
    .o_exec_en(exec_en), .i_is_load(is_load), .i_is_store(is_store),
    .i_br_taken(br_taken), .o_lsu_req(lsu_req), .i_lsu_ack(lsu_ack),
    .o_wb_en(wb_en), .o_pc_inc(pc_inc), .o_pc_load(pc_load), .o_trap(trap),
    .o_instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {halted, fetch_req, dec_en, exec_en, lsu_req, wb_en, pc_inc, pc_load, trap};
  endfunction

  task automatic drive(input logic [8:0] v);
    {clk_en, stall, halt_req, fetch_ack, illegal, is_load, is_store, br_taken, lsu_ack} = v;
  endtask

  task automatic check(input string name, input logic [8:0] exp, input longint unsigned cnt);
    logic [8:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s outputs got=%b want=%b", name, got, exp);
    end
    total++;
    if (instret !== CW'(cnt)) begin
      bad++;
      $display("FAIL %s instret got=%0d want=%0d", name, instret, cnt);
    end
    total++;
    if (fetch_req && lsu_req) begin
      bad++;
      $display("FAIL %s req_overlap got=11 want=not both", name);
    end
  endtask

  // Drive at posedge+1, compare mid-cycle, then advance one clock.
  task automatic step(input string name, input logic [8:0] in, input logic [8:0] exp,
                      input longint unsigned cnt);
    drive(in);
    #2;
    check(name, exp, cnt);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic [8:0] i, input logic [8:0] e,
                              input longint unsigned c);
    vec_t v;
    v.name = n; v.in = i; v.exp = e; v.cnt = c;
    vecs.push_back(v);
  endfunction

  initial begin
    // ALU-only stream with fetch ack tied high
    add("idle",      I_EN|I_FACK, O_NONE,       0);
    for (int k = 0; k < 3; k++) begin
      add("alu_fetch",  I_EN|I_FACK, O_FREQ,       longint'(k));
      add("alu_decode", I_EN|I_FACK, O_DEC,        longint'(k));
      add("alu_exec",   I_EN|I_FACK, O_EXE,        longint'(k));
      add("alu_wb",     I_EN|I_FACK, O_WB|O_INC,   longint'(k));
    end
    // Load, ack after 3 waiting cycles, stalled for the first 2
    add("ld_fetch",   I_EN|I_FACK,          O_FREQ,     3);
    add("ld_decode",  I_EN,                 O_DEC,      3);
    add("ld_exec",    I_EN|I_LOAD,          O_EXE,      3);
    add("ld_mem_st1", I_EN|I_STALL,         O_NONE,     3);
    add("ld_mem_st2", I_EN|I_STALL,         O_NONE,     3);
    add("ld_mem_w",   I_EN,                 O_LSU,      3);
    add("ld_mem_ack", I_EN|I_LACK,          O_LSU,      3);
    add("ld_wb",      I_EN,                 O_WB|O_INC, 3);
    // Store (ack while stalled in both FETCH and MEM), then taken branch
    add("st_fetch_stall_ack", I_EN|I_STALL|I_FACK, O_NONE, 4);
    add("st_decode",  I_EN,                 O_DEC,      4);
    add("st_exec",    I_EN|I_STORE,         O_EXE,      4);
    add("st_mem_stall_ack", I_EN|I_STALL|I_LACK, O_NONE, 4);
    add("st_wb",      I_EN,                 O_INC,      4);
    add("br_fetch_wait", I_EN,              O_FREQ,     5);
    add("br_fetch",   I_EN|I_FACK,          O_FREQ,     5);
    add("br_decode",  I_EN,                 O_DEC,      5);
    add("br_exec",    I_EN|I_BR,            O_EXE,      5);
    add("br_wb",      I_EN,                 O_WB|O_PCL, 5);
    // Illegal instruction trap
    add("ill_fetch",  I_EN|I_FACK,          O_FREQ,     6);
    add("ill_decode", I_EN|I_ILL,           O_DEC|O_TRAP|O_PCL, 6);
    // Halt raised in EXEC waits for retirement
    add("h_fetch",    I_EN|I_FACK,          O_FREQ,     6);
    add("h_decode",   I_EN,                 O_DEC,      6);
    add("h_exec",     I_EN|I_HALT,          O_EXE,      6);
    add("h_wb",       I_EN|I_HALT,          O_WB|O_INC, 6);
    add("h_halt",     I_EN|I_HALT,          O_HALT,     7);
    add("h_release",  I_EN,                 O_HALT,     7);
    add("h_fetch_after", I_EN,              O_FREQ,     7);
    // Clock-enable gating 1-0-1 across a load
    add("ce_fetch_off", I_FACK,             O_FREQ,     7);
    add("ce_fetch_on",  I_EN|I_FACK,        O_FREQ,     7);
    add("ce_dec_off",   O_NONE,             O_NONE,     7);
    add("ce_dec_on",    I_EN,               O_DEC,      7);
    add("ce_exec_off",  I_LOAD,             O_NONE,     7);
    add("ce_exec_on",   I_EN|I_LOAD,        O_EXE,      7);
    add("ce_mem_off",   I_LACK,             O_LSU,      7);
    add("ce_mem_on",    I_EN,               O_LSU,      7);
    add("ce_mem_ack",   I_EN|I_LACK,        O_LSU,      7);
    add("ce_wb_off",    O_NONE,             O_NONE,     7);
    add("ce_wb_on",     I_EN,               O_WB|O_INC, 7);
    add("ce_fetch_hold", O_NONE,            O_FREQ,     8);

    rst_n = 1'b0;
    drive(O_NONE);
    #3;
    check("reset", O_NONE, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp, vecs[i].cnt);

    // Walk into MEM with a load, then assert reset mid-cycle
    step("r_fetch",  I_EN|I_FACK, O_FREQ, 8);
    step("r_decode", I_EN,        O_DEC,  8);
    step("r_exec",   I_EN|I_LOAD, O_EXE,  8);
    drive(I_EN);
    #2;
    check("r_mem", O_LSU, 8);
    rst_n = 1'b0;
    #1;
    check("r_async", O_NONE, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Halt requested straight out of IDLE
    step("i_idle_halt", I_EN|I_HALT, O_NONE, 0);
    step("i_halted",    I_EN|I_HALT, O_HALT, 0);
    step("i_release",   I_EN,        O_HALT, 0);
    step("i_fetch",     I_EN,        O_FREQ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
